// File: rtl/ps2_dir_decoder.sv
// PS/2 receiver + make/break decoder steering the sprite direction; optional extended arrow keys via PS2_ARROW_EN.
// Latency: outputs update one clk after the stop-bit sampling event; the inputs carry ~2+FILTER_LEN cycles of conditioning delay.
// Backpressure: none; the PS/2 device is free-running and every byte is handled on arrival.
module ps2_dir_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] scan_code_o,
    output logic       code_valid_o,
    output logic       frame_err_o,
    output logic       move_en_o,
    output logic [1:0] direct_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          sample_evt, ps2_dat;

    state_t        state, state_nxt;
    logic [7:0]    shift_q, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          par_q, par_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          good, err;

    logic          ext_q, brk_q;
    logic [3:0]    held, held_nxt;
    logic          map_hit;
    logic [1:0]    map_dir, dir_nxt;

    // Synchronisers idle high so reset does not fake a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            dat_sync  <= {dat_sync[0], ps2_data_i};
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= ~filt_clk;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign sample_evt = filt_prev & ~filt_clk;
    assign ps2_dat    = dat_sync[1];

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_q;
        good        = 1'b0;
        err         = 1'b0;
        if (sample_evt) begin
            case (state)
                IDLE: if (!ps2_dat) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
                DATA: begin
                    shift_nxt   = {ps2_dat, shift_q[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = ps2_dat;
                    state_nxt = STOP;
                end
                STOP: begin
                    if (ps2_dat && (^{shift_q, par_q})) good = 1'b1;
                    else                               err  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            // A sampling event in the same cycle takes the branch above instead.
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_q   <= par_nxt;
            if (sample_evt || state_nxt == IDLE) tmo_cnt <= '0;
            else                                 tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Key map; index order matches the direct_o encoding.
    always_comb begin
        map_hit = 1'b0;
        map_dir = 2'd0;
        if (!ext_q) begin
            case (shift_q)
                8'h1D:   begin map_hit = 1'b1; map_dir = 2'd0; end
                8'h1B:   begin map_hit = 1'b1; map_dir = 2'd1; end
                8'h1C:   begin map_hit = 1'b1; map_dir = 2'd2; end
                8'h23:   begin map_hit = 1'b1; map_dir = 2'd3; end
                default: map_hit = 1'b0;
            endcase
        end else begin
`ifdef PS2_ARROW_EN
            case (shift_q)
                8'h75:   begin map_hit = 1'b1; map_dir = 2'd0; end
                8'h72:   begin map_hit = 1'b1; map_dir = 2'd1; end
                8'h6B:   begin map_hit = 1'b1; map_dir = 2'd2; end
                8'h74:   begin map_hit = 1'b1; map_dir = 2'd3; end
                default: map_hit = 1'b0;
            endcase
`else
            map_hit = 1'b0;
`endif
        end
    end

    always_comb begin
        held_nxt = held;
        dir_nxt  = direct_o;
        if (good && shift_q != 8'hE0 && shift_q != 8'hF0 && map_hit) begin
            if (brk_q) begin
                held_nxt[map_dir] = 1'b0;
                // Releasing the active key falls back to the lowest-index key still down.
                if (map_dir == direct_o) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (held_nxt[i]) dir_nxt = 2'(i);
                    end
                end
            end else begin
                held_nxt[map_dir] = 1'b1;
                dir_nxt           = map_dir;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_code_o  <= '0;
            code_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            move_en_o    <= 1'b0;
            direct_o     <= 2'd0;
            held         <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            code_valid_o <= good;
            frame_err_o  <= err;
            held         <= held_nxt;
            direct_o     <= dir_nxt;
            move_en_o    <= |held_nxt;
            if (good) begin
                scan_code_o <= shift_q;
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed PS/2 frames against a key-state model of the decoder, plus literal spot checks.
module tb_ps2_dir_decoder;
    localparam int FL   = 8;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] scan_code_o;
    logic       code_valid_o, frame_err_o, move_en_o;
    logic [1:0] direct_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int cv_seen = 0;
    int err_seen = 0;
    int exp_err = 0;
    logic [7:0] exp_q[$];

    logic [3:0] m_held = '0;
    logic [1:0] m_dir = '0;
    logic [7:0] m_scan = '0;
    logic       m_ext = 1'b0, m_brk = 1'b0;

    ps2_dir_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .scan_code_o(scan_code_o), .code_valid_o(code_valid_o), .frame_err_o(frame_err_o),
        .move_en_o(move_en_o), .direct_o(direct_o)
    );

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int key_dir(input logic [7:0] b, input logic ext);
        if (!ext) begin
            case (b)
                8'h1D: return 0;
                8'h1B: return 1;
                8'h1C: return 2;
                8'h23: return 3;
                default: return -1;
            endcase
        end
`ifdef PS2_ARROW_EN
        case (b)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
`else
        return -1;
`endif
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int d;
        m_scan = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            d = key_dir(b, m_ext);
            if (d >= 0) begin
                if (m_brk) begin
                    m_held[d] = 1'b0;
                    if (d == int'(m_dir)) begin
                        for (int i = 0; i < 4; i++) begin
                            if (m_held[i]) begin m_dir = 2'(i); break; end
                        end
                    end
                end else begin
                    m_held[d] = 1'b1;
                    m_dir = 2'(d);
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_held = '0; m_dir = '0; m_scan = '0; m_ext = 1'b0; m_brk = 1'b0;
            chk("reset_outputs", {scan_code_o, code_valid_o, frame_err_o, move_en_o, direct_o}, 0);
        end else begin
            if (code_valid_o && frame_err_o) chk("pulse_overlap", frame_err_o, 0);
            if (code_valid_o) begin
                cv_seen++;
                chk("valid_expected", code_valid_o, 32'(exp_q.size() > 0));
                if (exp_q.size() > 0) begin
                    logic [7:0] b;
                    b = exp_q.pop_front();
                    chk("scan_on_valid", scan_code_o, b);
                    model_byte(b);
                end
            end
            if (frame_err_o) begin
                err_seen++;
                chk("err_expected", frame_err_o, 32'(exp_err > 0));
                if (exp_err > 0) exp_err--;
            end
            chk("direct", direct_o, m_dir);
            chk("move_en", move_en_o, |m_held);
            chk("scan_hold", scan_code_o, m_scan);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data_i = bits[i];
            wait_cyc(HALF);
            ps2_clk_i = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk_i = 1'b1;
            if (glitch && i == 3) begin
                wait_cyc(10);
                ps2_clk_i = 1'b0;
                wait_cyc(3);
                ps2_clk_i = 1'b1;
            end
        end
        ps2_data_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
        logic par;
        par = (~^b) ^ bad_par;
        if (!bad_par && stop) exp_q.push_back(b);
        else exp_err++;
        send_bits({stop, par, b, 1'b0}, 11, glitch);
        wait_cyc(4 * HALF);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d required_below=100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cv0, er0, k;
        wait_cyc(3);
        @(negedge clk);
        chk("rst_scan", scan_code_o, 8'h00);
        chk("rst_move", move_en_o, 0);
        chk("rst_dir", direct_o, 2'b00);
        @(posedge clk); #2 rst = 1'b1;
        wait_cyc(20);

        // 0x1D: data 1,0,1,1,1,0,0,0, parity 1, stop 1
        send_frame(8'h1D, 0, 1, 0);
        @(negedge clk);
        chk("w_scan", scan_code_o, 8'h1D);
        chk("w_dir", direct_o, 2'b00);
        chk("w_move", move_en_o, 1);
        chk("w_cv_count", cv_seen, 1);

        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h1D, 0, 1, 0);
        @(negedge clk);
        chk("w_rel_move", move_en_o, 0);
        chk("w_rel_dir", direct_o, 2'b00);
        chk("w_rel_cv_count", cv_seen, 3);

        send_frame(8'h1C, 0, 1, 0);
        @(negedge clk); chk("a_dir", direct_o, 2'b10);
        send_frame(8'h23, 0, 1, 0);
        @(negedge clk); chk("ad_dir", direct_o, 2'b11);
        send_frame(8'hF0, 0, 1, 0);
        send_frame(8'h23, 0, 1, 0);
        @(negedge clk);
        chk("d_rel_dir", direct_o, 2'b10);
        chk("d_rel_move", move_en_o, 1);

        cv0 = cv_seen; er0 = err_seen;
        send_frame(8'h1D, 1, 1, 0);
        send_frame(8'h1D, 0, 0, 0);
        @(negedge clk);
        chk("bad_err_count", err_seen - er0, 2);
        chk("bad_cv_count", cv_seen - cv0, 0);
        chk("bad_scan", scan_code_o, 8'h23);
        chk("bad_dir", direct_o, 2'b10);

        // Partial frame: start + 4 data bits, then the clock stops.
        er0 = err_seen;
        exp_err++;
        send_bits({2'b11, 8'h1D, 1'b0}, 5, 0);
        k = 0;
        while (!frame_err_o && k < TO + 200) begin @(negedge clk); k++; end
        chk("timeout_seen", frame_err_o, 1);
        chk("timeout_window", 32'((cyc - last_fall_cyc) >= TO && (cyc - last_fall_cyc) <= TO + 20), 1);
        wait_cyc(HALF);
        send_frame(8'h1B, 0, 1, 0);
        @(negedge clk);
        chk("s_dir", direct_o, 2'b01);
        chk("timeout_err_count", err_seen - er0, 1);

        send_frame(8'h23, 0, 1, 1);
        @(negedge clk);
        chk("glitch_scan", scan_code_o, 8'h23);
        chk("glitch_dir", direct_o, 2'b11);

        send_frame(8'h1C, 0, 1, 0);
        send_frame(8'hE0, 0, 1, 0);
        send_frame(8'h74, 0, 1, 0);
        @(negedge clk);
`ifdef PS2_ARROW_EN
        chk("ext_right_dir", direct_o, 2'b11);
`else
        chk("ext_right_dir", direct_o, 2'b10);
`endif
        chk("ext_move", move_en_o, 1);

        // Reset in the middle of a frame.
        send_bits({2'b11, 8'h1B, 1'b0}, 4, 0);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("mid_rst_move", move_en_o, 0);
        chk("mid_rst_dir", direct_o, 2'b00);
        chk("mid_rst_scan", scan_code_o, 8'h00);
        wait_cyc(5);
        ps2_clk_i = 1'b1; ps2_data_i = 1'b1;
        @(posedge clk); #2 rst = 1'b1;
        wait_cyc(20);
        send_frame(8'h1D, 0, 1, 0);
        @(negedge clk);
        chk("post_rst_scan", scan_code_o, 8'h1D);
        chk("post_rst_move", move_en_o, 1);

        chk("pending_valid", exp_q.size(), 0);
        chk("pending_err", exp_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
